trax_board_engine: RTL

Parametrised Trax board store and tile-placement engine that replaces the fixed 5x5 table logic. It accepts one move per handshake and checks legality and edge-colour consistency. It writes the 3-bit cell, then grows the occupied window and shifts the board down or right so that an empty border ring is always kept. It sits between the move transceiver and the move-selection logic, and gives them a registered read port into the board.

---
 rtl/trax_board_engine.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/trax_board_engine.sv
// Trax board store and tile-placement engine: validates one move per handshake,
// writes the cell, then shifts/grows the window so an empty border ring remains.
module trax_board_engine #(
  parameter int MAX_ROW = 8,
  parameter int MAX_COL = 8,
  parameter int IDX_W   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mv_valid,
  output logic                 mv_ready,
  input  logic [2*IDX_W+1:0]   mv_data,
  input  logic                 clr,
  output logic                 done,
  output logic [1:0]           err,
  output logic [IDX_W-1:0]     n_rows,
  output logic [IDX_W-1:0]     n_cols,
  output logic [IDX_W+1:0]     tile_cnt,
  input  logic [IDX_W-1:0]     rd_row,
  input  logic [IDX_W-1:0]     rd_col,
  output logic [2:0]           rd_cell
);
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WRITE, S_SHIFT_D, S_SHIFT_R, S_GROW, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
  localparam logic [IDX_W:0]   ROW_CAP = (IDX_W+1)'(MAX_ROW);
  localparam logic [IDX_W:0]   COL_CAP = (IDX_W+1)'(MAX_COL);

  state_t             r_state, w_next;
  logic [2:0]         r_cell [MAX_ROW][MAX_COL];
  logic [IDX_W-1:0]   r_row, r_col, r_cnt, r_n_rows, r_n_cols;
  logic [1:0]         r_tile, r_err;
  logic               r_c, r_done, r_grow_r, r_grow_c;
  logic [IDX_W+1:0]   r_tile_cnt;
  logic [2:0]         r_rd_cell;

  logic [2:0]         w_tgt;
  logic [2:0]         w_nb [4];
  logic [1:0]         w_xr, w_xc, w_err;
  logic               w_illegal, w_full, w_conf, w_set, w_c, w_req;
  logic               w_clear, w_last;
  logic [IDX_W-1:0]   w_span, w_dst;

  // Edge inversion relative to the top colour; side 0 up, 1 down, 2 left, 3 right
  function automatic logic inv(input logic [1:0] t, input logic [1:0] s);
    case (t)
      2'b01:   inv = s[1];
      2'b10:   inv = (s == 2'd1) || (s == 2'd3);
      2'b11:   inv = (s == 2'd1) || (s == 2'd2);
      default: inv = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] get_cell(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    get_cell = 3'b000;
    for (int i = 0; i < MAX_ROW; i++)
      for (int j = 0; j < MAX_COL; j++)
        if (r == IDX_W'(i) && c == IDX_W'(j)) get_cell = r_cell[i][j];
  endfunction

  assign w_clear = (r_state == S_IDLE) && clr;
  assign w_span  = (r_state == S_SHIFT_R) ? r_n_cols : r_n_rows;
  assign w_last  = (r_cnt == w_span - ONE);
  assign w_dst   = w_span - r_cnt;

  always_comb begin
    w_tgt    = get_cell(r_row, r_col);
    w_nb[0]  = (r_row != '0) ? get_cell(r_row - ONE, r_col) : 3'b000;
    w_nb[1]  = get_cell(r_row + ONE, r_col);
    w_nb[2]  = (r_col != '0) ? get_cell(r_row, r_col - ONE) : 3'b000;
    w_nb[3]  = get_cell(r_row, r_col + ONE);
    w_illegal = (r_row >= r_n_rows) || (r_col >= r_n_cols) || (w_tgt != 3'b000) ||
                ((r_tile_cnt != '0) && (w_nb[0][2:1] == 2'b00) && (w_nb[1][2:1] == 2'b00) &&
                 (w_nb[2][2:1] == 2'b00) && (w_nb[3][2:1] == 2'b00));
    w_xr   = {1'b0, r_row == '0} + {1'b0, r_row == r_n_rows - ONE};
    w_xc   = {1'b0, r_col == '0} + {1'b0, r_col == r_n_cols - ONE};
    w_full = (({1'b0, r_n_rows} + {{(IDX_W-1){1'b0}}, w_xr}) > ROW_CAP) ||
             (({1'b0, r_n_cols} + {{(IDX_W-1){1'b0}}, w_xc}) > COL_CAP);
    // First occupied neighbour fixes the top colour; later ones must agree
    w_c    = 1'b0;
    w_set  = 1'b0;
    w_conf = 1'b0;
    w_req  = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (w_nb[s][2:1] != 2'b00) begin
        w_req = w_nb[s][0] ^ inv(w_nb[s][2:1], 2'(s ^ 1)) ^ inv(r_tile, 2'(s));
        if (!w_set) begin
          w_c   = w_req;
          w_set = 1'b1;
        end else if (w_req != w_c) begin
          w_conf = 1'b1;
        end
      end
    end
    if (w_illegal)   w_err = 2'b01;
    else if (w_full) w_err = 2'b11;
    else if (w_conf) w_err = 2'b10;
    else             w_err = 2'b00;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (mv_valid && !clr) w_next = S_CHECK;
      S_CHECK:   w_next = (w_err != 2'b00) ? S_DONE : S_WRITE;
      S_WRITE:   w_next = (r_row == '0) ? S_SHIFT_D : (r_col == '0) ? S_SHIFT_R : S_GROW;
      S_SHIFT_D: if (w_last) w_next = (r_col == '0) ? S_SHIFT_R : S_GROW;
      S_SHIFT_R: if (w_last) w_next = S_GROW;
      S_GROW:    w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_tile     <= 2'b00;
      r_c        <= 1'b0;
      r_err      <= 2'b00;
      r_done     <= 1'b0;
      r_grow_r   <= 1'b0;
      r_grow_c   <= 1'b0;
      r_cnt      <= '0;
      r_n_rows   <= ONE;
      r_n_cols   <= ONE;
      r_tile_cnt <= '0;
    end else if (w_clear) begin
      r_state    <= S_IDLE;
      r_err      <= 2'b00;
      r_done     <= 1'b0;
      r_n_rows   <= ONE;
      r_n_cols   <= ONE;
      r_tile_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: if (mv_valid) {r_tile, r_col, r_row} <= mv_data;
        S_CHECK: begin
          r_err    <= w_err;
          r_c      <= w_c;
          r_grow_r <= (r_row == r_n_rows - ONE);
          r_grow_c <= (r_col == r_n_cols - ONE);
          r_cnt    <= '0;
        end
        S_WRITE: r_tile_cnt <= r_tile_cnt + (IDX_W+2)'(1);
        S_SHIFT_D, S_SHIFT_R: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_state == S_SHIFT_D) r_n_rows <= r_n_rows + ONE;
            else                      r_n_cols <= r_n_cols + ONE;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        S_GROW: begin
          if (r_grow_r) r_n_rows <= r_n_rows + ONE;
          if (r_grow_c) r_n_cols <= r_n_cols + ONE;
        end
        default: ;
      endcase
    end
  end

  // Shift step t moves line (span-1-t) to (span-t); the last step blanks line 0
  for (genvar gi = 0; gi < MAX_ROW; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_COL; gj++) begin : g_col
      localparam int UP = (gi > 0) ? gi - 1 : 0;
      localparam int LF = (gj > 0) ? gj - 1 : 0;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cell[gi][gj] <= 3'b000;
        end else if (w_clear) begin
          r_cell[gi][gj] <= 3'b000;
        end else begin
          case (r_state)
            S_WRITE:
              if (r_row == IDX_W'(gi) && r_col == IDX_W'(gj)) r_cell[gi][gj] <= {r_tile, r_c};
            S_SHIFT_D:
              if (gi > 0 && w_dst == IDX_W'(gi)) r_cell[gi][gj] <= r_cell[UP][gj];
              else if (gi == 0 && w_last)        r_cell[gi][gj] <= 3'b000;
            S_SHIFT_R:
              if (gj > 0 && w_dst == IDX_W'(gj)) r_cell[gi][gj] <= r_cell[gi][LF];
              else if (gj == 0 && w_last)        r_cell[gi][gj] <= 3'b000;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_rd_cell <= 3'b000;
    else if (w_clear) r_rd_cell <= 3'b000;
    else              r_rd_cell <= get_cell(rd_row, rd_col);
  end

  assign mv_ready = (r_state == S_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign n_rows   = r_n_rows;
  assign n_cols   = r_n_cols;
  assign tile_cnt = r_tile_cnt;
  assign rd_cell  = r_rd_cell;
endmodule
